spgemm_pingpong_pe: RTL and testbench

SPGEMM_PINGPONG_PE -- requirements
Module: spgemm_pingpong_pe

---
 rtl/spgemm_pkg.sv | 18 +
 rtl/spgemm_lsb_enc.sv | 18 +
 rtl/spgemm_pingpong_pe.sv | 155 +++++++++++++++
 tb/tb_spgemm_pingpong_pe.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spgemm_pkg.sv
// Shared types and width defaults for the sparse GEMM row-merge datapath
// (also used by matraptor_core).
`timescale 1ns/1ps
package spgemm_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 16;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } bank_state_t;

  // A bank can take input beats until its row has been closed.
  function automatic logic bank_open(input bank_state_t s);
    return s != READY;
  endfunction
endpackage

// File: rtl/spgemm_lsb_enc.sv
// Priority encoder: index of the lowest set bit of vec, plus an any-set flag.
`timescale 1ns/1ps
module spgemm_lsb_enc #(
  parameter int WIDTH = 8,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/spgemm_pingpong_pe.sv
// Ping-pong row accumulator: one bank merges partial products of a row by
// column while the other bank streams the previous row out in column order.
`timescale 1ns/1ps
module spgemm_pingpong_pe
  import spgemm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int NQ      = 8,
  parameter int Q_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_val,
  input  logic [IDX_W-1:0]  in_row,
  input  logic [IDX_W-1:0]  in_col,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_col,
  output logic [IDX_W-1:0]  out_row,
  output logic              out_last,
  output logic              row_done,
  output logic              err_oor
);
  localparam int COL_RANGE = NQ * Q_DEPTH;
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int AW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = QW + AW;
  localparam logic [IDX_W:0] COL_LIM = (IDX_W + 1)'(COL_RANGE);

  // Accumulation wraps modulo 2^DATA_W; no saturation by design.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  bank_state_t st [2];
  bank_state_t st_nxt [2];
  logic        fill_ptr, fill_ptr_nxt;
  logic        drain_ptr, drain_ptr_nxt;
  logic [COL_RANGE-1:0]     bmp [2];
  logic signed [DATA_W-1:0] mem [2][COL_RANGE];
  logic [IDX_W-1:0]         row_id [2];
  logic        err_oor_p1;
  logic        row_done_p1;

  // ---- fill stage: accept beat, read-modify-write the fill bank ----
  logic          in_fire;
  logic          in_range;
  logic          hit;
  logic [CW-1:0] in_addr;

  assign in_ready = bank_open(st[fill_ptr]);
  assign in_fire  = in_valid && in_ready;
  assign in_range = {1'b0, in_col} < COL_LIM;
  assign in_addr  = in_col[CW-1:0];
  assign hit      = bmp[fill_ptr][in_addr];

  // ---- drain stage: lowest occupied column of the drain bank ----
  logic [COL_RANGE-1:0] dbm;
  logic [NQ-1:0]        q_ne;
  logic [Q_DEPTH-1:0]   q_bits;
  logic [QW-1:0]        q_idx;
  logic [AW-1:0]        a_idx;
  logic                 q_any, a_any;
  logic [CW-1:0]        d_col;
  logic                 drain_rdy, only_one, out_fire, drain_last, empty_done;

  assign dbm = bmp[drain_ptr];
  for (genvar q = 0; q < NQ; q++) begin : g_qne
    assign q_ne[q] = |dbm[q*Q_DEPTH +: Q_DEPTH];
  end

  spgemm_lsb_enc #(.WIDTH(NQ)) u_q_enc (
    .vec (q_ne),
    .idx (q_idx),
    .any (q_any)
  );

  assign q_bits = dbm[int'(q_idx)*Q_DEPTH +: Q_DEPTH];

  spgemm_lsb_enc #(.WIDTH(Q_DEPTH)) u_a_enc (
    .vec (q_bits),
    .idx (a_idx),
    .any (a_any)
  );

  assign d_col      = {q_idx, a_idx};
  assign drain_rdy  = (st[drain_ptr] == READY);
  assign out_valid  = drain_rdy && q_any && a_any;
  // Final entry: exactly one queue occupied and it holds a single entry.
  assign only_one   = ~|(q_ne & (q_ne - NQ'(1))) && ~|(q_bits & (q_bits - Q_DEPTH'(1)));
  assign out_fire   = out_valid && out_ready;
  assign drain_last = out_fire && only_one;
  assign empty_done = drain_rdy && !q_any;

  assign out_val  = out_valid ? mem[drain_ptr][d_col] : '0;
  assign out_col  = out_valid ? IDX_W'(d_col) : '0;
  assign out_row  = out_valid ? row_id[drain_ptr] : '0;
  assign out_last = out_valid && only_one;
  assign err_oor  = err_oor_p1;
  assign row_done = row_done_p1;

  // ---- bank control: next state ----
  always_comb begin
    st_nxt        = st;
    fill_ptr_nxt  = fill_ptr;
    drain_ptr_nxt = drain_ptr;
    if (in_fire) begin
      st_nxt[fill_ptr] = in_last ? READY : FILLING;
      if (in_last) fill_ptr_nxt = ~fill_ptr;
    end
    if (drain_last || empty_done) begin
      st_nxt[drain_ptr] = FREE;
      drain_ptr_nxt     = ~drain_ptr;
    end
  end

  // ---- p1 boundary: control and occupancy registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]       <= FREE;
      st[1]       <= FREE;
      fill_ptr    <= 1'b0;
      drain_ptr   <= 1'b0;
      bmp[0]      <= '0;
      bmp[1]      <= '0;
      err_oor_p1  <= 1'b0;
      row_done_p1 <= 1'b0;
    end else begin
      st          <= st_nxt;
      fill_ptr    <= fill_ptr_nxt;
      drain_ptr   <= drain_ptr_nxt;
      err_oor_p1  <= in_fire && !in_range;
      row_done_p1 <= drain_last || empty_done;
      if (in_fire && in_range) bmp[fill_ptr][in_addr] <= 1'b1;
      if (out_fire) bmp[drain_ptr][d_col] <= 1'b0;
    end
  end

  // Entry values and row ids are qualified by the bitmap/state, so no reset.
  always_ff @(posedge clk) begin
    if (in_fire && in_range) begin
      mem[fill_ptr][in_addr] <= hit ? wrap_add(mem[fill_ptr][in_addr], $signed(in_val))
                                    : $signed(in_val);
    end
    if (in_fire && st[fill_ptr] == FREE) row_id[fill_ptr] <= in_row;
  end
endmodule

// File: tb/tb_spgemm_pingpong_pe.sv
// Bench for spgemm_pingpong_pe: directed row table, multi-cycle corner
// sequences and randomized rows against a column-map reference model.
`timescale 1ns/1ps
module tb_spgemm_pingpong_pe;
  localparam int DATA_W = 32, IDX_W = 16, NQ = 8, Q_DEPTH = 256;
  localparam int COL_RANGE = NQ * Q_DEPTH;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [31:0] in_val = '0;
  logic [15:0] in_row = '0, in_col = '0;
  logic        out_valid, out_last, row_done, err_oor;
  logic        out_ready = 1'b0;
  logic [31:0] out_val;
  logic [15:0] out_col, out_row;

  spgemm_pingpong_pe #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NQ(NQ), .Q_DEPTH(Q_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_row(in_row),
    .in_col(in_col), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_col(out_col),
    .out_row(out_row), .out_last(out_last), .row_done(row_done), .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int ordy_mode = 0;  // 0: hold off, 1: always ready, 2: random
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (ordy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = (ordy_mode == 1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each open row is a column->sum map; closing a row
  // emits its columns in ascending order.
  typedef struct { logic [31:0] val; int col; int row; bit last; int cyc; } ent_t;
  ent_t        exp_q[$];
  ent_t        obs_q[$];
  logic [31:0] acc[int];
  bit          row_open = 0;
  int          cur_row = 0, exp_rows = 0, exp_oor = 0, done_cnt = 0, err_cnt = 0;
  int          done_cyc_q[$], err_cyc_q[$];
  bit          prev_stall = 0;
  ent_t        prev_o;

  function automatic void model_beat(int row, int col, logic [31:0] v, bit last);
    if (!row_open) begin
      row_open = 1;
      cur_row  = row;
    end
    if (col < COL_RANGE) begin
      if (acc.exists(col)) acc[col] = acc[col] + v;
      else acc[col] = v;
    end else exp_oor++;
    if (last) begin
      int n, k;
      n = acc.num();
      k = 0;
      foreach (acc[c]) begin
        ent_t e;
        k++;
        e.val = acc[c]; e.col = c; e.row = cur_row; e.last = (k == n); e.cyc = 0;
        exp_q.push_back(e);
      end
      acc.delete();
      row_open = 0;
      exp_rows++;
    end
  endfunction

  task automatic model_reset();
    exp_q.delete(); acc.delete(); obs_q.delete();
    row_open = 0; exp_rows = 0; exp_oor = 0; done_cnt = 0; err_cnt = 0;
  endtask

  always @(negedge clk) begin
    ent_t o, e;
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 0);
      check("rst_pulses", 64'({row_done, err_oor}), 0);
      prev_stall = 0;
    end else begin
      if (in_valid && in_ready) model_beat(int'(in_row), int'(in_col), in_val, in_last);
      if (row_done) begin done_cnt++; done_cyc_q.push_back(cyc); end
      if (err_oor) begin err_cnt++; err_cyc_q.push_back(cyc); end
      o.val = out_val; o.col = int'(out_col); o.row = int'(out_row); o.last = out_last; o.cyc = cyc;
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 1);
        check("hold_val", 64'(out_val), 64'(prev_o.val));
        check("hold_col", 64'(o.col), 64'(prev_o.col));
        check("hold_row", 64'(o.row), 64'(prev_o.row));
        check("hold_last", 64'(out_last), 64'(prev_o.last));
      end
      if (!out_valid)
        check("idle_zero", 64'(out_val | 32'(out_col) | 32'(out_row) | 32'(out_last)), 0);
      if (out_valid && out_ready) begin
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_unexpected: got col %0d row %0d, required no output", o.col, o.row);
        end else begin
          e = exp_q.pop_front();
          check("out_col", 64'(o.col), 64'(e.col));
          check("out_val", 64'(out_val), 64'(e.val));
          check("out_row", 64'(o.row), 64'(e.row));
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_o = o;
    end
  end

  task automatic send_beat(input int row, input int col, input logic [31:0] v, input bit last,
                           output int acc_c);
    in_valid = 1; in_row = row[15:0]; in_col = col[15:0]; in_val = v; in_last = last;
    acc_c = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready) begin acc_c = cyc; break; end
    end
    if (acc_c < 0) begin
      tests++; fails++;
      $display("FAIL beat_timeout: in_ready stayed 0 for col %0d, required 1", col);
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_quiet(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !row_open && done_cnt == exp_rows) begin ok = 1; break; end
    end
    check(name, 64'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    int               row, nb;
    logic [3:0][15:0] col;
    logic [3:0][31:0] val;
    int               ne;
    logic [3:0][15:0] ecol;
    logic [3:0][31:0] evl;
    int               eerr;
  } vec_t;

  function automatic vec_t mk(input int row, input int nb, input int c0, c1, c2, c3,
                              input logic [31:0] v0, v1, v2, v3, input int ne,
                              input int e0, e1, e2, e3, input logic [31:0] x0, x1, x2, x3,
                              input int eerr);
    vec_t t;
    t.row = row; t.nb = nb; t.ne = ne; t.eerr = eerr;
    t.col[0] = c0[15:0]; t.col[1] = c1[15:0]; t.col[2] = c2[15:0]; t.col[3] = c3[15:0];
    t.val[0] = v0; t.val[1] = v1; t.val[2] = v2; t.val[3] = v3;
    t.ecol[0] = e0[15:0]; t.ecol[1] = e1[15:0]; t.ecol[2] = e2[15:0]; t.ecol[3] = e3[15:0];
    t.evl[0] = x0; t.evl[1] = x1; t.evl[2] = x2; t.evl[3] = x3;
    return t;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int acc_c[4];
    int oor_c, d0, e0, last_acc;
    obs_q.delete(); done_cyc_q.delete(); err_cyc_q.delete();
    d0 = done_cnt; e0 = err_cnt; oor_c = -1;
    for (int b = 0; b < v.nb; b++) begin
      send_beat(v.row, int'(v.col[b]), v.val[b], b == v.nb - 1, acc_c[b]);
      if (int'(v.col[b]) >= COL_RANGE) oor_c = acc_c[b];
    end
    last_acc = acc_c[v.nb-1];
    wait_quiet($sformatf("vec%0d_drained", id));
    check($sformatf("vec%0d_nostall", id), 64'(last_acc - acc_c[0]), 64'(v.nb - 1));
    check($sformatf("vec%0d_count", id), 64'(obs_q.size()), 64'(v.ne));
    for (int i = 0; i < v.ne && i < obs_q.size(); i++) begin
      check($sformatf("vec%0d_col%0d", id, i), 64'(obs_q[i].col), 64'(v.ecol[i]));
      check($sformatf("vec%0d_val%0d", id, i), 64'(obs_q[i].val), 64'(v.evl[i]));
      check($sformatf("vec%0d_row%0d", id, i), 64'(obs_q[i].row), 64'(v.row));
      check($sformatf("vec%0d_last%0d", id, i), 64'(obs_q[i].last), 64'(i == v.ne - 1));
      if (i > 0) check($sformatf("vec%0d_bubble%0d", id, i), 64'(obs_q[i].cyc), 64'(obs_q[i-1].cyc + 1));
    end
    if (v.ne > 0 && obs_q.size() > 0 && done_cyc_q.size() > 0) begin
      check($sformatf("vec%0d_first_lat", id), 64'(obs_q[0].cyc), 64'(last_acc + 1));
      check($sformatf("vec%0d_done_cyc", id), 64'(done_cyc_q[0]), 64'(obs_q[obs_q.size()-1].cyc + 1));
    end else if (done_cyc_q.size() > 0)
      check($sformatf("vec%0d_empty_done_cyc", id), 64'(done_cyc_q[0]), 64'(last_acc + 2));
    check($sformatf("vec%0d_done_pulses", id), 64'(done_cnt - d0), 1);
    check($sformatf("vec%0d_err_pulses", id), 64'(err_cnt - e0), 64'(v.eerr));
    if (oor_c >= 0 && err_cyc_q.size() > 0)
      check($sformatf("vec%0d_err_cyc", id), 64'(err_cyc_q[0]), 64'(oor_c + 1));
  endtask

  vec_t tbl [7];
  int   dummy, rise_c, a_last, nb, col, sel;
  logic [31:0] v;

  initial begin
    tbl[0] = mk(3, 3, 5, 5, 2, 0, 10, 7, 1, 0, 2, 2, 5, 0, 0, 1, 17, 0, 0, 0);
    tbl[1] = mk(0, 3, 300, 1, 2047, 0, 11, 22, 33, 0, 3, 1, 300, 2047, 0, 22, 11, 33, 0, 0);
    tbl[2] = mk(7, 2, 9, 9, 0, 0, 32'hFFFF_FFFF, 2, 0, 0, 1, 9, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[3] = mk(4, 1, 2048, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4] = mk(12, 2, 100, 100, 0, 0, 5, 32'hFFFF_FFFB, 0, 0, 1, 100, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5] = mk(13, 3, 4000, 255, 256, 0, 9, 3, 4, 0, 2, 255, 256, 0, 0, 3, 4, 0, 0, 1);
    tbl[6] = mk(14, 4, 1792, 0, 1792, 0, 1, 2, 3, 4, 2, 0, 1792, 0, 0, 6, 4, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1; rst_n = 1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 1);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_row_done", 64'(row_done), 0);
    @(posedge clk); #1;

    ordy_mode = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Row A stalled, row B fills the other bank, row C must wait for A.
    ordy_mode = 0;
    @(posedge clk); #1;
    obs_q.delete();
    for (int b = 0; b < 4; b++) send_beat(20, 1 + b, 32'(b + 1), b == 3, dummy);
    send_beat(21, 7, 70, 0, dummy);
    send_beat(21, 8, 80, 1, dummy);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pp_in_ready_blocked", 64'(in_ready), 0);
    end
    @(posedge clk); #1;
    ordy_mode = 1;
    send_beat(22, 9, 99, 1, rise_c);
    wait_quiet("pp_drained");
    a_last = -100;
    foreach (obs_q[i]) if (obs_q[i].row == 20 && obs_q[i].last) a_last = obs_q[i].cyc;
    check("pp_ready_rise", 64'(rise_c), 64'(a_last + 1));
    check("pp_count", 64'(obs_q.size()), 7);
    if (obs_q.size() == 7) begin
      check("pp_order_a", 64'(obs_q[3].row), 20);
      check("pp_order_b", 64'(obs_q[4].row), 21);
      check("pp_order_c", 64'(obs_q[6].row), 22);
    end

    // Randomized rows with random output back-pressure.
    ordy_mode = 2;
    for (int r = 0; r < 40; r++) begin
      nb = $urandom_range(1, 12);
      for (int b = 0; b < nb; b++) begin
        sel = $urandom_range(0, 15);
        if (sel == 0) col = 2048 + $urandom_range(0, 5000);
        else if (sel < 6) col = $urandom_range(0, 7);
        else if (sel < 11) col = 250 + $urandom_range(0, 10);
        else col = 2040 + $urandom_range(0, 7);
        v = $urandom;
        if (sel == 1) v = 0;
        send_beat(100 + r, col, v, b == nb - 1, dummy);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    ordy_mode = 1;
    wait_quiet("rand_drained");
    check("rand_rows", 64'(done_cnt), 64'(exp_rows));
    check("rand_oor", 64'(err_cnt), 64'(exp_oor));

    // Reset in the middle of draining a 5-entry row.
    ordy_mode = 0;
    @(posedge clk); #1;
    for (int b = 0; b < 5; b++) send_beat(30, 10 * (b + 1), 32'(b + 5), b == 4, dummy);
    repeat (2) @(negedge clk);
    check("mid_out_valid", 64'(out_valid), 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("async_out_valid", 64'(out_valid), 0);
    check("async_out_last", 64'(out_last), 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 1);
    check("post_rst_out_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    ordy_mode = 1;
    send_beat(31, 20, 77, 1, dummy);
    wait_quiet("post_rst_drained");
    check("post_rst_count", 64'(obs_q.size()), 1);
    if (obs_q.size() > 0) begin
      check("post_rst_col", 64'(obs_q[0].col), 20);
      check("post_rst_val", 64'(obs_q[0].val), 77);
    end
    check("post_rst_rows", 64'(done_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
